// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 cache port between the I-side and D-side
// L1 caches; latches the winner's request, strobes the L2 and returns its answer.
module l2_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int BLOCK_SIZE = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            r0_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] r0_data_in,
    input  logic                             r0_read,
    input  logic                             r0_write,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] r0_data_out,
    output logic                             r0_ready,
    output logic                             r0_hit,
    output logic                             r0_err,
    input  logic [ADDR_WIDTH-1:0]            r1_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] r1_data_in,
    input  logic                             r1_read,
    input  logic                             r1_write,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] r1_data_out,
    output logic                             r1_ready,
    output logic                             r1_hit,
    output logic                             r1_err,
    output logic [ADDR_WIDTH-1:0]            l2_cache_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_cache_data_in,
    output logic                             l2_cache_read,
    output logic                             l2_cache_write,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_cache_data_out,
    input  logic                             l2_cache_ready,
    input  logic                             l2_hit,
    output logic                             busy
);
    localparam int BW = BLOCK_SIZE * DATA_WIDTH;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                r_state, w_state_next;
    logic                  r_grant, r_last_grant, r_op_write;
    logic                  r_l2_read, r_l2_write;
    logic [CW-1:0]         r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BW-1:0]         r_wdata;

    logic [1:0]            w_active, w_write;
    logic [ADDR_WIDTH-1:0] w_addr [2];
    logic [BW-1:0]         w_wdata [2];
    logic                  w_pick, w_expire, w_start, w_l2_done, w_abort;
    logic [1:0]            w_ready, w_hit, w_err;
    logic [BW-1:0]         w_data_out [2];

    assign w_active   = {r1_read | r1_write, r0_read | r0_write};
    assign w_write    = {r1_write, r0_write};
    assign w_addr[0]  = r0_addr;
    assign w_addr[1]  = r1_addr;
    assign w_wdata[0] = r0_data_in;
    assign w_wdata[1] = r1_data_in;

    // Round-robin pointer only decides ties; a lone requester always wins.
    assign w_pick   = (&w_active) ? ~r_last_grant : w_active[1];
    assign w_expire = (r_count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_l2_done    = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_active) begin
                    w_start      = 1'b1;
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (l2_cache_ready) begin
                    w_l2_done    = 1'b1;
                    w_state_next = RESP;
                end else if (w_expire) begin
                    w_abort      = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_op_write   <= 1'b0;
            r_l2_read    <= 1'b0;
            r_l2_write   <= 1'b0;
            r_count      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_l2_read  <= 1'b0;
            r_l2_write <= 1'b0;
            if (w_start) begin
                r_grant    <= w_pick;
                r_op_write <= w_write[w_pick];
                r_addr     <= w_addr[w_pick];
                r_wdata    <= w_wdata[w_pick];
                r_l2_read  <= ~w_write[w_pick];
                r_l2_write <= w_write[w_pick];
                r_count    <= '0;
            end else if (w_l2_done || w_abort) begin
                r_last_grant <= r_grant;
            end else if (r_state == WAIT) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        logic          r_ready, r_hit, r_err;
        logic [BW-1:0] r_data_out;
        logic          w_mine;

        assign w_mine = (r_grant == 1'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ready    <= 1'b0;
                r_hit      <= 1'b0;
                r_err      <= 1'b0;
                r_data_out <= '0;
            end else begin
                r_ready <= 1'b0;
                r_hit   <= 1'b0;
                r_err   <= 1'b0;
                if (w_mine && w_l2_done) begin
                    r_ready <= 1'b1;
                    r_hit   <= l2_hit;
                    // Writes return no block, so the last read block is kept.
                    if (!r_op_write) begin
                        r_data_out <= l2_cache_data_out;
                    end
                end else if (w_mine && w_abort) begin
                    r_ready <= 1'b1;
                    r_err   <= 1'b1;
                end
            end
        end

        assign w_ready[gi]    = r_ready;
        assign w_hit[gi]      = r_hit;
        assign w_err[gi]      = r_err;
        assign w_data_out[gi] = r_data_out;
    end

    assign r0_ready    = w_ready[0];
    assign r0_hit      = w_hit[0];
    assign r0_err      = w_err[0];
    assign r0_data_out = w_data_out[0];
    assign r1_ready    = w_ready[1];
    assign r1_hit      = w_hit[1];
    assign r1_err      = w_err[1];
    assign r1_data_out = w_data_out[1];

    assign l2_cache_addr    = r_addr;
    assign l2_cache_data_in = r_wdata;
    assign l2_cache_read    = r_l2_read;
    assign l2_cache_write   = r_l2_write;
    assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter: directed requests push expected strobes
// and responses; an independent monitor pops and compares them as they appear.
module tb_l2_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 11;
    localparam int BS = 32;
    localparam int TO = 8;
    localparam int BW = BS * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [BW-1:0] r0_data_in, r1_data_in;
    logic          r0_read, r0_write, r1_read, r1_write;
    logic [BW-1:0] r0_data_out, r1_data_out;
    logic          r0_ready, r0_hit, r0_err, r1_ready, r1_hit, r1_err;
    logic [AW-1:0] l2_cache_addr;
    logic [BW-1:0] l2_cache_data_in, l2_cache_data_out;
    logic          l2_cache_read, l2_cache_write, l2_cache_ready, l2_hit;
    logic          busy;

    l2_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_addr(r0_addr), .r0_data_in(r0_data_in), .r0_read(r0_read), .r0_write(r0_write),
        .r0_data_out(r0_data_out), .r0_ready(r0_ready), .r0_hit(r0_hit), .r0_err(r0_err),
        .r1_addr(r1_addr), .r1_data_in(r1_data_in), .r1_read(r1_read), .r1_write(r1_write),
        .r1_data_out(r1_data_out), .r1_ready(r1_ready), .r1_hit(r1_hit), .r1_err(r1_err),
        .l2_cache_addr(l2_cache_addr), .l2_cache_data_in(l2_cache_data_in),
        .l2_cache_read(l2_cache_read), .l2_cache_write(l2_cache_write),
        .l2_cache_data_out(l2_cache_data_out), .l2_cache_ready(l2_cache_ready),
        .l2_hit(l2_hit), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } strb_t;

    typedef struct {
        int            n;
        int            cyc;
        logic          hit;
        logic          err;
        logic          capture;
        logic [BW-1:0] blk;
        string         tag;
    } resp_t;

    strb_t         exp_strb[$];
    resp_t         exp_resp[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic [BW-1:0] mon_data [2];
    logic          l2_respond;
    logic          l2_hit_val;
    logic [31:0]   l2_seed;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [BW-1:0] block_of(input logic [31:0] seed);
        logic [BW-1:0] b;
        for (int i = 0; i < BS; i++) b[i*DW +: DW] = seed ^ 32'(i);
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_blk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            int w;
            w = 0;
            for (int i = BS - 1; i >= 0; i--) if (act[i*DW +: DW] !== exp[i*DW +: DW]) w = i;
            n_fail++;
            $display("FAIL %s: word %0d got %08h expected %08h (cycle %0d)",
                     name, w, act[w*DW +: DW], exp[w*DW +: DW], cyc);
        end
    endtask

    task automatic set_req(input int n, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [BW-1:0] d);
        if (n == 0) begin
            r0_read = rd; r0_write = wr; r0_addr = a; r0_data_in = d;
        end else begin
            r1_read = rd; r1_write = wr; r1_addr = a; r1_data_in = d;
        end
    endtask

    // Holds a request until its ready pulse is seen, then drops it at once.
    task automatic request(input int n, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [BW-1:0] d);
        bit seen;
        seen = 1'b0;
        set_req(n, rd, wr, a, d);
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            seen = (n == 0) ? r0_ready : r1_ready;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL ready_wait r%0d: got no ready within 60 cycles, expected one pulse", n);
        end
        set_req(n, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic expect_txn(input int n, input logic rd, input logic wr,
                              input logic [AW-1:0] a, input logic [BW-1:0] d,
                              input int issue, input int lat, input logic hit,
                              input logic err, input logic [BW-1:0] rblk, input string tag);
        strb_t s;
        resp_t r;
        s.wr = wr; s.addr = a; s.data = d;
        exp_strb.push_back(s);
        r.n = n; r.cyc = issue + lat; r.hit = hit; r.err = err;
        r.capture = rd && !wr && !err; r.blk = rblk; r.tag = tag;
        exp_resp.push_back(r);
    endtask

    // L2 model: answers one cycle after it sees a strobe, when enabled.
    initial begin
        l2_cache_ready    = 1'b0;
        l2_hit            = 1'b0;
        l2_cache_data_out = '0;
        forever begin
            @(negedge clk);
            l2_cache_ready = 1'b0;
            l2_hit         = 1'b0;
            if (rst_n && l2_respond && (l2_cache_read || l2_cache_write)) begin
                l2_cache_ready    = 1'b1;
                l2_hit            = l2_hit_val;
                l2_cache_data_out = block_of(l2_seed);
            end
        end
    end

    initial begin
        strb_t         s;
        resp_t         r;
        logic [BW-1:0] exp_d;
        int            got_n;
        forever begin
            @(negedge clk);
            if (l2_cache_read || l2_cache_write) begin
                chk("strobe_exclusive", 64'(l2_cache_read & l2_cache_write), 64'(0));
                if (exp_strb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL strobe_unexpected: got read=%0b write=%0b addr=%0h, expected no strobe",
                             l2_cache_read, l2_cache_write, l2_cache_addr);
                end else begin
                    s = exp_strb.pop_front();
                    chk("strobe_write", 64'(l2_cache_write), 64'(s.wr));
                    chk("strobe_addr", 64'(l2_cache_addr), 64'(s.addr));
                    chk("busy_in_txn", 64'(busy), 64'(1));
                    if (s.wr) chk_blk("strobe_wdata", l2_cache_data_in, s.data);
                end
            end
            if (r0_ready || r1_ready) begin
                chk("ready_exclusive", 64'(r0_ready & r1_ready), 64'(0));
                got_n = r1_ready ? 1 : 0;
                if (exp_resp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ready_unexpected: got ready on r%0d, expected none", got_n);
                end else begin
                    r = exp_resp.pop_front();
                    exp_d = r.capture ? r.blk : mon_data[r.n];
                    chk("resp_port", 64'(got_n), 64'(r.n));
                    chk("resp_hit", 64'((got_n == 1) ? r1_hit : r0_hit), 64'(r.hit));
                    chk("resp_err", 64'((got_n == 1) ? r1_err : r0_err), 64'(r.err));
                    chk("resp_cycle", 64'(cyc), 64'(r.cyc));
                    chk_blk("resp_data", (r.n == 1) ? r1_data_out : r0_data_out, exp_d);
                    chk_blk("other_data_hold", (r.n == 1) ? r0_data_out : r1_data_out, mon_data[1 - r.n]);
                    mon_data[r.n] = exp_d;
                    $display("txn %s: r%0d ready hit=%0b err=%0b word0=%08h cycle=%0d",
                             r.tag, got_n, (got_n == 1) ? r1_hit : r0_hit,
                             (got_n == 1) ? r1_err : r0_err, exp_d[DW-1:0], cyc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        int            issue;
        logic [BW-1:0] wblk_a;
        logic [BW-1:0] wblk_b;
        logic [BW-1:0] wblk_c;
        wblk_a = block_of(32'hA5A5A5A5);
        wblk_b = block_of(32'h0F0F0000);
        wblk_c = block_of(32'h5A5A0000);
        mon_data[0] = '0;
        mon_data[1] = '0;
        l2_respond = 1'b1;
        l2_hit_val = 1'b0;
        l2_seed    = 32'hDEADBEEF;

        // Reset held with both requesters active.
        rst_n = 1'b0;
        set_req(0, 1'b1, 1'b0, 11'h00A, '0);
        set_req(1, 1'b0, 1'b1, 11'h014, wblk_a);
        repeat (3) @(negedge clk);
        chk("rst_r0_ready", 64'(r0_ready), 64'(0));
        chk("rst_r0_hit", 64'(r0_hit), 64'(0));
        chk("rst_r0_err", 64'(r0_err), 64'(0));
        chk("rst_r1_ready", 64'(r1_ready), 64'(0));
        chk("rst_r1_hit", 64'(r1_hit), 64'(0));
        chk("rst_r1_err", 64'(r1_err), 64'(0));
        chk("rst_l2_read", 64'(l2_cache_read), 64'(0));
        chk("rst_l2_write", 64'(l2_cache_write), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_l2_addr", 64'(l2_cache_addr), 64'(0));
        chk_blk("rst_l2_data_in", l2_cache_data_in, '0);
        chk_blk("rst_r0_data_out", r0_data_out, '0);
        chk_blk("rst_r1_data_out", r1_data_out, '0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Tie right after reset: r0 first, r1 granted two edges after r0's ready.
        l2_seed = 32'h0BADF00D;
        issue = cyc + 1;
        expect_txn(0, 1'b1, 1'b0, 11'h00A, '0, issue, 1, 1'b0, 1'b0, block_of(l2_seed), "tie1_r0_read");
        expect_txn(1, 1'b0, 1'b1, 11'h014, wblk_a, issue, 4, 1'b0, 1'b0, '0, "tie1_r1_write");
        fork
            request(0, 1'b1, 1'b0, 11'h00A, '0);
            request(1, 1'b0, 1'b1, 11'h014, wblk_a);
        join
        repeat (2) @(negedge clk);

        // Single read on r0, hit=0.
        l2_seed = 32'hDEADBEEF;
        issue = cyc + 1;
        expect_txn(0, 1'b1, 1'b0, 11'h00A, '0, issue, 1, 1'b0, 1'b0, block_of(l2_seed), "single_r0_read");
        request(0, 1'b1, 1'b0, 11'h00A, '0);
        repeat (2) @(negedge clk);

        // r0 won last, so this tie goes to r1 first.
        l2_seed    = 32'hCAFE0000;
        l2_hit_val = 1'b1;
        issue = cyc + 1;
        expect_txn(1, 1'b1, 1'b0, 11'h021, '0, issue, 1, 1'b1, 1'b0, block_of(l2_seed), "tie2_r1_read");
        expect_txn(0, 1'b0, 1'b1, 11'h02A, wblk_b, issue, 4, 1'b1, 1'b0, '0, "tie2_r0_write");
        fork
            request(0, 1'b0, 1'b1, 11'h02A, wblk_b);
            request(1, 1'b1, 1'b0, 11'h021, '0);
        join
        repeat (2) @(negedge clk);

        // Read and write together on r1 is a write.
        issue = cyc + 1;
        expect_txn(1, 1'b1, 1'b1, 11'h3FF, wblk_c, issue, 1, 1'b1, 1'b0, '0, "r1_read_and_write");
        request(1, 1'b1, 1'b1, 11'h3FF, wblk_c);
        repeat (2) @(negedge clk);

        // L2 never answers: abort exactly TO edges after the request edge.
        l2_respond = 1'b0;
        issue = cyc + 1;
        expect_txn(0, 1'b1, 1'b0, 11'h100, '0, issue, TO, 1'b0, 1'b1, '0, "timeout_r0");
        request(0, 1'b1, 1'b0, 11'h100, '0);
        repeat (2) @(negedge clk);

        l2_respond = 1'b1;
        l2_seed    = 32'h13579BDF;
        issue = cyc + 1;
        expect_txn(0, 1'b1, 1'b0, 11'h101, '0, issue, 1, 1'b1, 1'b0, block_of(l2_seed), "after_timeout_r0");
        request(0, 1'b1, 1'b0, 11'h101, '0);
        repeat (2) @(negedge clk);

        // Reset while waiting on the L2: only the original strobe may appear.
        l2_respond = 1'b0;
        begin
            strb_t s;
            s.wr = 1'b0; s.addr = 11'h033; s.data = '0;
            exp_strb.push_back(s);
        end
        set_req(1, 1'b1, 1'b0, 11'h033, '0);
        begin
            bit seen_busy;
            seen_busy = 1'b0;
            for (int k = 0; k < 20 && !seen_busy; k++) begin
                @(negedge clk);
                seen_busy = busy;
            end
            chk("wait_busy_seen", 64'(seen_busy), 64'(1));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        set_req(1, 1'b0, 1'b0, '0, '0);
        mon_data[0] = '0;
        mon_data[1] = '0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_l2_read", 64'(l2_cache_read), 64'(0));
        chk("midrst_l2_addr", 64'(l2_cache_addr), 64'(0));
        chk("midrst_r1_ready", 64'(r1_ready), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        l2_respond = 1'b1;
        repeat (2) @(negedge clk);

        // Pointer back to reset value: tie goes to r0 again.
        l2_seed    = 32'h2468ACE0;
        l2_hit_val = 1'b0;
        issue = cyc + 1;
        expect_txn(0, 1'b1, 1'b0, 11'h00A, '0, issue, 1, 1'b0, 1'b0, block_of(l2_seed), "tie3_r0_read");
        expect_txn(1, 1'b1, 1'b0, 11'h014, '0, issue, 4, 1'b0, 1'b0, block_of(l2_seed), "tie3_r1_read");
        fork
            request(0, 1'b1, 1'b0, 11'h00A, '0);
            request(1, 1'b1, 1'b0, 11'h014, '0);
        join
        repeat (3) @(negedge clk);

        chk("strobe_queue_empty", 64'(exp_strb.size()), 64'(0));
        chk("resp_queue_empty", 64'(exp_resp.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
